// File: rtl/sram_req_arbiter_pkg.sv
// Shared types and constants for the two-requester SRAM-like port arbiter.
package sram_req_arbiter_pkg;

   typedef enum logic {
      SRC_INST = 1'b0,
      SRC_DATA = 1'b1
   } src_e;

   localparam int unsigned OT_DEPTH_DEFAULT = 4;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;
   localparam int unsigned SIZE_W = 2;

   // Request payload carried from a requester onto the shared port
   typedef struct packed {
      logic              wr;
      logic [SIZE_W-1:0] size;
      logic [ADDR_W-1:0] addr;
      logic [STRB_W-1:0] wstrb;
      logic [DATA_W-1:0] wdata;
   } sram_req_t;

   function automatic sram_req_t pick_req(input src_e sel, input sram_req_t inst_f,
                                          input sram_req_t data_f);
      return (sel == SRC_DATA) ? data_f : inst_f;
   endfunction

endpackage

// File: rtl/resp_order_fifo.sv
// In-order record of which requester owns each outstanding transaction.
module resp_order_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   din,
   output logic                   head,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [DEPTH-1:0] mem;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between inst and data requesters: fixed data-first
// priority, grant held while the port stalls, responses routed in issue order.
module sram_req_arbiter
   import sram_req_arbiter_pkg::*;
#(
   parameter int unsigned OT_DEPTH = OT_DEPTH_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        req,
   output logic        wr,
   output logic [1:0]  size,
   output logic [31:0] addr,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   input  logic        addr_ok,
   input  logic        data_ok,
   input  logic [31:0] rdata
);
   localparam int unsigned CW = $clog2(OT_DEPTH) + 1;

   src_e          sel;
   src_e          lock_sel;
   logic          locked;
   sram_req_t     inst_f;
   sram_req_t     data_f;
   sram_req_t     sel_f;
   logic          accept;
   logic          ot_empty;
   logic          ot_full;
   logic          ot_head;
   logic [CW-1:0] ot_count;

   assign inst_f = '{wr: inst_wr, size: inst_size, addr: inst_addr,
                     wstrb: inst_wstrb, wdata: inst_wdata};
   assign data_f = '{wr: data_wr, size: data_size, addr: data_addr,
                     wstrb: data_wstrb, wdata: data_wdata};

   // A stalled grant keeps the port until addr_ok; otherwise data wins
   always_comb begin
      sel = SRC_INST;
      if (locked) begin
         sel = lock_sel;
      end else if (data_req) begin
         sel = SRC_DATA;
      end
   end

   assign sel_f  = pick_req(sel, inst_f, data_f);
   assign req    = !ot_full && (locked || inst_req || data_req);
   assign wr     = sel_f.wr;
   assign size   = sel_f.size;
   assign addr   = sel_f.addr;
   assign wstrb  = sel_f.wstrb;
   assign wdata  = sel_f.wdata;
   assign accept = req && addr_ok;

   assign inst_addr_ok = accept && (sel == SRC_INST);
   assign data_addr_ok = accept && (sel == SRC_DATA);
   assign inst_data_ok = data_ok && !ot_empty && (ot_head == SRC_INST);
   assign data_data_ok = data_ok && !ot_empty && (ot_head == SRC_DATA);
   assign inst_rdata   = rdata;
   assign data_rdata   = rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         locked   <= 1'b0;
         lock_sel <= SRC_DATA;
      end else if (req) begin
         if (!addr_ok) begin
            locked   <= 1'b1;
            lock_sel <= sel;
         end else begin
            locked   <= 1'b0;
         end
      end
   end

   resp_order_fifo #(
      .DEPTH(OT_DEPTH)
   ) u_order (
      .clk  (clk),
      .reset(reset),
      .push (accept),
      .pop  (data_ok),
      .din  (sel),
      .head (ot_head),
      .empty(ot_empty),
      .full (ot_full),
      .count(ot_count)
   );

   // A response with nothing outstanding is dropped; flag it loudly
   a_no_orphan_data_ok : assert property (@(posedge clk) disable iff (reset)
      !(data_ok && ot_empty))
      else $warning("sram_req_arbiter: data_ok with no outstanding transaction dropped");

   a_count_bound : assert property (@(posedge clk) disable iff (reset)
      ot_count <= CW'(OT_DEPTH));

endmodule

// File: doc/sram_req_arbiter.md
SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 Parameter OT_DEPTH, default 4: maximum outstanding (address-accepted, data-pending) transactions; power of two, at least 2.
REQ-002 Port `clk`, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 Port `reset`, input, 1 bit: reset, synchronous and active-high.
REQ-004 Inst-side request group: `inst_req` in 1, `inst_wr` in 1, `inst_size` in 2, `inst_addr` in 32, `inst_wstrb` in 4, `inst_wdata` in 32.
REQ-005 Inst-side response group: `inst_addr_ok` out 1, `inst_data_ok` out 1, `inst_rdata` out 32.
REQ-006 Data-side group: `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wstrb`, `data_wdata` (inputs); `data_addr_ok`, `data_data_ok`, `data_rdata` (outputs); widths as inst side.
REQ-007 Shared-port outputs: `req` 1, `wr` 1, `size` 2, `addr` 32, `wstrb` 4, `wdata` 32, driving the single SRAM-like port.
REQ-008 Shared-port inputs: `addr_ok` 1, `data_ok` 1, `rdata` 32, from the single SRAM-like port.

Function
REQ-009 The block SHALL share one SRAM-like port between the inst and data requesters; a transaction is accepted when req && addr_ok, and completes when data_ok is seen later.
REQ-010 Arbitration SHALL be fixed priority, data over inst, applied only when no grant is locked.
REQ-011 Lock rule: when req=1 and addr_ok=0, the current selection SHALL be registered and held on following cycles until addr_ok=1, even if the higher-priority side asserts meanwhile.
REQ-012 On the addr_ok=1 cycle the lock SHALL clear, and the next cycle SHALL re-arbitrate.
REQ-013 Shared-port field selection: wr, size, addr, wstrb and wdata SHALL be combinationally muxed from the selected side.
REQ-014 Shared-port `req` SHALL equal !ot_full && (locked || inst_req || data_req).
REQ-015 `inst_addr_ok` SHALL equal addr_ok && req && sel==INST; `data_addr_ok` SHALL equal addr_ok && req && sel==DATA; the unselected side sees 0.
REQ-016 An in-order source FIFO (1-bit entries, OT_DEPTH deep) SHALL push the selected source on each accept cycle.
REQ-017 The source FIFO SHALL pop on each data_ok cycle while it is non-empty.
REQ-018 `inst_data_ok` SHALL equal data_ok && !empty && head==INST; `data_data_ok` likewise for DATA; `rdata` SHALL be passed combinationally to both rdata outputs.
REQ-019 Full condition: when count==OT_DEPTH, req SHALL be 0, including when a pop happens in the same cycle (no same-cycle bypass).
REQ-020 A push and a pop in the same cycle SHALL leave count unchanged and keep the entry order correct; pointers SHALL wrap modulo OT_DEPTH.
REQ-021 data_ok arriving with the FIFO empty SHALL be dropped (both data_ok outputs 0, no state change) and flagged by a simulation assertion.
REQ-022 Requesters hold their request fields stable from req until addr_ok; the block does not check this.

Reset
REQ-023 While reset=1 at a clock edge, the FIFO SHALL be emptied (count=0, pointers=0) and the lock cleared, with sel returning to DATA priority.
REQ-024 After the reset edge, req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok SHALL be 0 until new requests arrive.
REQ-025 A reset mid-transaction SHALL discard all pending entries; the shared port is reset in the same cycle.

Structure
REQ-026 A shared package SHALL hold SRC_INST=1'b0, SRC_DATA=1'b1 and the OT_DEPTH default.
REQ-027 The source FIFO SHALL be one sub-module, resp_order_fifo (push, pop, din, head, empty, full, count).
REQ-028 Lock and priority selection SHALL stay in the top module.

Verification
REQ-029 Both sides request in cycle 0 with addr_ok=1: data accepted in cycle 0, inst in cycle 1; data_ok in cycles 2 and 3 routes to data then inst.
REQ-030 inst_req alone with addr_ok held 0 for 3 cycles, data_req rising in cycle 1: addr stays the inst address; inst_addr_ok is asserted in cycle 3; data is accepted in cycle 4.
REQ-031 Four inst accepts with no data_ok: req=0 in cycle 4; data_ok in cycle 5 pops one entry; req=1 again in cycle 6.
REQ-032 Push and pop in the same cycle at count=2: count stays 2; the head order matches the issue sequence (D,I,D).
REQ-033 data_ok while empty: both data_ok outputs 0 and the assertion fires; reset with 3 pending entries gives count=0 and req=0 in the next cycle.
